// File: rtl/udp_reg_master.sv
// Register-ring master: turns one host request into a ring request and waits for its return.
// Optional return timeout is enabled by defining UDP_REG_MASTER_TIMEOUT_EN.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_master #(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int SRC_ADDR = 0,
    parameter int TIMEOUT = 127,
    parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] BAD_DATA = 32'hdead_beef
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            core_reg_req,
    input  logic                            core_reg_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
    output logic                            core_reg_ack,

    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,

    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ADDR);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("udp_reg_master: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                            state_reg;
    state_t                            state_next;
    logic                              ret_match;
    logic                              timeout_hit;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]   result_next;

    // Returned address and direction carry no information for the master.
    logic unused_ring_bits;
    assign unused_ring_bits = ^{reg_rd_wr_L_in, reg_addr_in};

`ifdef UDP_REG_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_reg;

    // Counter holds k-1 in the k-th WAIT cycle, so WAIT lasts exactly TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg == S_ISSUE) begin
            cnt_reg <= '0;
        end else if (state_reg == S_WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == S_WAIT) && (cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        ret_match   = (state_reg == S_WAIT) && reg_req_in && (reg_src_in == SRC_TAG);
        result_next = (ret_match && reg_ack_in) ? reg_data_in : BAD_DATA;

        case (state_reg)
            S_IDLE:  if (core_reg_req) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            // A return coinciding with timeout expiry wins via result_next.
            S_WAIT:  if (ret_match || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            reg_req_out      <= 1'b0;
            reg_ack_out      <= 1'b0;
            reg_rd_wr_L_out  <= 1'b1;
            reg_addr_out     <= '0;
            reg_data_out     <= '0;
            reg_src_out      <= '0;
            core_reg_ack     <= 1'b0;
            core_reg_rd_data <= '0;
        end else begin
            state_reg        <= state_next;
            reg_req_out      <= 1'b0;
            reg_ack_out      <= 1'b0;
            reg_rd_wr_L_out  <= 1'b1;
            reg_addr_out     <= '0;
            reg_data_out     <= '0;
            reg_src_out      <= '0;
            // The ring output registers double as the request latch; ISSUE is only entered from IDLE.
            if (state_reg == S_IDLE && core_reg_req) begin
                reg_req_out     <= 1'b1;
                reg_rd_wr_L_out <= core_reg_rd_wr_L;
                reg_addr_out    <= core_reg_addr;
                reg_data_out    <= core_reg_wr_data;
                reg_src_out     <= SRC_TAG;
            end
            core_reg_ack <= (state_next == S_DONE);
            if (state_reg == S_WAIT && state_next == S_DONE) begin
                core_reg_rd_data <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_udp_reg_master.sv
// Directed bench for udp_reg_master; covers both builds of UDP_REG_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_master;

    localparam int AW  = `UDP_REG_ADDR_WIDTH;
    localparam int DW  = `CPCI_NF2_DATA_WIDTH;
    localparam int SW  = 2;
    localparam int SRC = 1;
    localparam int TMO = 127;
    localparam logic [DW-1:0] BAD = 32'hdead_beef;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_reg_req;
    logic          core_reg_rd_wr_L;
    logic [AW-1:0] core_reg_addr;
    logic [DW-1:0] core_reg_wr_data;
    logic [DW-1:0] core_reg_rd_data;
    logic          core_reg_ack;
    logic          reg_req_out;
    logic          reg_ack_out;
    logic          reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [SW-1:0] reg_src_out;
    logic          reg_req_in;
    logic          reg_ack_in;
    logic          reg_rd_wr_L_in;
    logic [AW-1:0] reg_addr_in;
    logic [DW-1:0] reg_data_in;
    logic [SW-1:0] reg_src_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    udp_reg_master #(
        .UDP_REG_SRC_WIDTH (SW),
        .SRC_ADDR          (SRC),
        .TIMEOUT           (TMO),
        .BAD_DATA          (BAD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_reg_req     (core_reg_req),
        .core_reg_rd_wr_L (core_reg_rd_wr_L),
        .core_reg_addr    (core_reg_addr),
        .core_reg_wr_data (core_reg_wr_data),
        .core_reg_rd_data (core_reg_rd_data),
        .core_reg_ack     (core_reg_ack),
        .reg_req_out      (reg_req_out),
        .reg_ack_out      (reg_ack_out),
        .reg_rd_wr_L_out  (reg_rd_wr_L_out),
        .reg_addr_out     (reg_addr_out),
        .reg_data_out     (reg_data_out),
        .reg_src_out      (reg_src_out),
        .reg_req_in       (reg_req_in),
        .reg_ack_in       (reg_ack_in),
        .reg_rd_wr_L_in   (reg_rd_wr_L_in),
        .reg_addr_in      (reg_addr_in),
        .reg_data_in      (reg_data_in),
        .reg_src_in       (reg_src_in)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ring_quiet();
        reg_req_in     = 1'b0;
        reg_ack_in     = 1'b0;
        reg_rd_wr_L_in = 1'b1;
        reg_addr_in    = '0;
        reg_data_in    = '0;
        reg_src_in     = '0;
    endtask

    task automatic drive_return(input logic [SW-1:0] src, input logic ack, input logic [DW-1:0] data);
        reg_req_in  = 1'b1;
        reg_src_in  = src;
        reg_ack_in  = ack;
        reg_data_in = data;
        reg_addr_in = 'h1;
    endtask

    // Strobe for one cycle; on return we are in the ISSUE cycle (N+1).
    task automatic host_strobe(input logic rd_wr_L, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        core_reg_req     = 1'b1;
        core_reg_rd_wr_L = rd_wr_L;
        core_reg_addr    = addr;
        core_reg_wr_data = wdata;
        tick();
        core_reg_req     = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic rd_wr_L, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
        check_eq({tag, "_req_out"}, reg_req_out, 1);
        check_eq({tag, "_ack_out"}, reg_ack_out, 0);
        check_eq({tag, "_rdwr_out"}, reg_rd_wr_L_out, rd_wr_L);
        check_eq({tag, "_addr_out"}, reg_addr_out, addr);
        check_eq({tag, "_data_out"}, reg_data_out, wdata);
        check_eq({tag, "_src_out"}, reg_src_out, SRC);
    endtask

    // Return is driven during WAIT cycle number 'delay' (1-based).
    task automatic run_txn(input string tag, input logic rd_wr_L, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int delay, input logic ret_ack,
                           input logic [DW-1:0] ret_data, input logic [DW-1:0] exp_rd);
        int early_acks;
        early_acks = 0;
        host_strobe(rd_wr_L, addr, wdata);
        check_issue(tag, rd_wr_L, addr, wdata);
        tick();
        check_eq({tag, "_req_one_cycle"}, reg_req_out, 0);
        for (int i = 1; i < delay; i++) begin
            if (core_reg_ack) early_acks++;
            tick();
        end
        drive_return(SW'(SRC), ret_ack, ret_data);
        if (core_reg_ack) early_acks++;
        check_eq({tag, "_early_acks"}, early_acks, 0);
        tick();
        ring_quiet();
        check_eq({tag, "_ack"}, core_reg_ack, 1);
        check_eq({tag, "_rd_data"}, core_reg_rd_data, exp_rd);
        tick();
        check_eq({tag, "_ack_drop"}, core_reg_ack, 0);
        check_eq({tag, "_rd_hold"}, core_reg_rd_data, exp_rd);
        $display("txn %s rd_wr_L=%0b addr=%0h wdata=%0h delay=%0d rd_data=%0h", tag, rd_wr_L, addr, wdata,
                 delay, core_reg_rd_data);
    endtask

    initial begin
        int acks;
        int reqs;
        reset            = 1'b1;
        core_reg_req     = 1'b0;
        core_reg_rd_wr_L = 1'b1;
        core_reg_addr    = '0;
        core_reg_wr_data = '0;
        ring_quiet();
        tick();
        tick();
        check_eq("rst_req_out", reg_req_out, 0);
        check_eq("rst_ack_out", reg_ack_out, 0);
        check_eq("rst_rdwr_out", reg_rd_wr_L_out, 1);
        check_eq("rst_addr_out", reg_addr_out, 0);
        check_eq("rst_data_out", reg_data_out, 0);
        check_eq("rst_src_out", reg_src_out, 0);
        check_eq("rst_core_ack", core_reg_ack, 0);
        check_eq("rst_rd_data", core_reg_rd_data, 0);
        $display("txn reset: outputs idle");
        reset = 1'b0;
        tick();

        run_txn("read_ok", 1'b1, 'h123, '0, 1, 1'b1, 32'h1234_5678, 32'h1234_5678);
        run_txn("read_unclaimed", 1'b1, 'h7ff, '0, 3, 1'b0, 32'h5555_5555, BAD);
        run_txn("write_40", 1'b0, 'h40, 32'hA5A5_A5A5, 2, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        run_txn("read_slow", 1'b1, 'h2a, '0, 9, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Stray matching return while idle must do nothing.
        drive_return(SW'(SRC), 1'b1, 32'h0000_0001);
        tick();
        ring_quiet();
        check_eq("idle_stray_ack", core_reg_ack, 0);
        check_eq("idle_stray_req_out", reg_req_out, 0);
        tick();
        check_eq("idle_stray_rd_hold", core_reg_rd_data, 32'hCAFE_F00D);
        $display("txn idle_stray: rd_data=%0h", core_reg_rd_data);

        // Second host request and foreign-source return during WAIT are both ignored.
        host_strobe(1'b1, 'h10, '0);
        check_issue("busy", 1'b1, 'h10, '0);
        tick();
        core_reg_req  = 1'b1;
        core_reg_addr = 'h20;
        drive_return(SW'(SRC + 1), 1'b1, 32'hBAD0_BAD0);
        tick();
        core_reg_req = 1'b0;
        ring_quiet();
        check_eq("busy_foreign_ack", core_reg_ack, 0);
        check_eq("busy_no_reissue", reg_req_out, 0);
        tick();
        check_eq("busy_foreign_ack2", core_reg_ack, 0);
        drive_return(SW'(SRC), 1'b1, 32'h600D_F00D);
        tick();
        ring_quiet();
        check_eq("busy_match_ack", core_reg_ack, 1);
        check_eq("busy_match_rd", core_reg_rd_data, 32'h600D_F00D);
        acks = 0;
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_reg_ack) acks++;
            if (reg_req_out) reqs++;
        end
        check_eq("busy_extra_acks", acks, 0);
        check_eq("busy_not_queued", reqs, 0);
        $display("txn busy: rd_data=%0h extra_acks=%0d extra_reqs=%0d", core_reg_rd_data, acks, reqs);

        // Reset during WAIT abandons the transaction; the late return is dropped.
        host_strobe(1'b1, 'h33, '0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_ack", core_reg_ack, 0);
        check_eq("midrst_rd_data", core_reg_rd_data, 0);
        drive_return(SW'(SRC), 1'b1, 32'h7777_7777);
        tick();
        ring_quiet();
        check_eq("midrst_late_ack", core_reg_ack, 0);
        tick();
        check_eq("midrst_late_ack2", core_reg_ack, 0);
        check_eq("midrst_rd_still0", core_reg_rd_data, 0);
        $display("txn midrst: late return ignored");
        run_txn("after_rst", 1'b1, 'h34, '0, 2, 1'b1, 32'h0102_0304, 32'h0102_0304);

`ifdef UDP_REG_MASTER_TIMEOUT_EN
        begin
            int  k;
            bit  seen;
            k    = 0;
            seen = 1'b0;
            host_strobe(1'b1, 'h99, '0);
            check_issue("timeout", 1'b1, 'h99, '0);
            while (k < 300 && !seen) begin
                tick();
                k++;
                if (core_reg_ack) seen = 1'b1;
            end
            check_eq("timeout_seen", seen, 1);
            check_eq("timeout_wait_cycles", k - 1, TMO);
            check_eq("timeout_rd_data", core_reg_rd_data, BAD);
            tick();
            check_eq("timeout_ack_drop", core_reg_ack, 0);
            $display("txn timeout: wait_cycles=%0d rd_data=%0h", k - 1, core_reg_rd_data);
        end
        run_txn("ret_wins", 1'b1, 'h55, '0, TMO, 1'b1, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
`else
        host_strobe(1'b1, 'h99, '0);
        check_issue("no_timeout", 1'b1, 'h99, '0);
        acks = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (core_reg_ack) acks++;
        end
        check_eq("no_timeout_acks", acks, 0);
        $display("txn no_timeout: acks in 1000 cycles=%0d", acks);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_txn("post_wait", 1'b1, 'h56, '0, 4, 1'b1, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_reg_master.md
UDP_REG_MASTER -- requirements
Module: udp_reg_master

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2, width of reg_src fields.
REQ-002 SHALL have parameter SRC_ADDR, default 0, source tag stamped on every issued request.
REQ-003 SHALL have parameter TIMEOUT, default 127, cycles to wait for a returning request before giving up.
REQ-004 SHALL have parameter BAD_DATA, default 32'hdead_beef, read data returned on unclaimed or timed-out requests.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port core_reg_req  input  1  one-cycle host request strobe.
REQ-008 SHALL have port core_reg_rd_wr_L  input  1  1 = read, 0 = write.
REQ-009 SHALL have port core_reg_addr  input  `UDP_REG_ADDR_WIDTH  register address.
REQ-010 SHALL have port core_reg_wr_data  input  `CPCI_NF2_DATA_WIDTH  write data.
REQ-011 SHALL have port core_reg_rd_data  output  `CPCI_NF2_DATA_WIDTH  read data, valid with core_reg_ack.
REQ-012 SHALL have port core_reg_ack  output  1  one-cycle completion strobe.
REQ-013 SHALL have ports reg_req_out, reg_ack_out, reg_rd_wr_L_out  output  1 each; reg_addr_out  output  `UDP_REG_ADDR_WIDTH; reg_data_out  output  `CPCI_NF2_DATA_WIDTH; reg_src_out  output  UDP_REG_SRC_WIDTH: ring head.
REQ-014 SHALL have ports reg_req_in, reg_ack_in, reg_rd_wr_L_in  input  1 each; reg_addr_in  input  `UDP_REG_ADDR_WIDTH; reg_data_in  input  `CPCI_NF2_DATA_WIDTH; reg_src_in  input  UDP_REG_SRC_WIDTH: ring tail.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; one transaction outstanding at a time.
REQ-016 IDLE: core_reg_req=1 SHALL latch rd_wr_L/addr/wr_data and go to ISSUE.
REQ-017 ISSUE: all ring outputs registered; for exactly one cycle reg_req_out=1, reg_ack_out=0, reg_src_out=SRC_ADDR, reg_rd_wr_L_out/reg_addr_out/reg_data_out = latched values; then WAIT.
REQ-018 Outside ISSUE, reg_req_out=0, reg_ack_out=0, reg_rd_wr_L_out=1, reg_addr_out=0, reg_data_out=0, reg_src_out=0.
REQ-019 WAIT: reg_req_in=1 with reg_src_in==SRC_ADDR SHALL end wait; go to DONE capturing result.
REQ-020 Result: reg_ack_in=1 -> rd_data=reg_data_in; reg_ack_in=0 (unclaimed) -> rd_data=BAD_DATA.
REQ-021 Writes SHALL return rd_data per REQ-020 as well; host ignores it.
REQ-022 DONE: core_reg_ack=1 and core_reg_rd_data=result for exactly one cycle; next cycle IDLE; core_reg_rd_data holds value until next completion.
REQ-023 Latency: host strobe cycle N -> reg_req_out at N+1; matching return at cycle M -> core_reg_ack at M+1.
REQ-024 core_reg_req in any state other than IDLE SHALL be ignored (not queued).
REQ-025 reg_req_in with reg_src_in!=SRC_ADDR, or any reg_req_in while not in WAIT, SHALL be discarded with no effect.
REQ-026 Return arriving in the same cycle the timeout expires SHALL be taken as a valid return (return wins).

Reset
REQ-027 reset=1 SHALL force IDLE, all outputs to REQ-018 values, core_reg_ack=0, core_reg_rd_data=0, timeout counter=0.
REQ-028 Reset mid-transaction SHALL abandon it without an ack; a late return afterwards is discarded per REQ-025.

Configuration
REQ-029 Macro UDP_REG_MASTER_TIMEOUT_EN defined: counter clears on entering WAIT, increments each WAIT cycle; reaching TIMEOUT with no return -> DONE with rd_data=BAD_DATA.
REQ-030 Macro undefined: no counter logic; WAIT persists until a matching return or reset.

Verification
REQ-031 Read, ring loopback with a target asserting ack and data 0x12345678 -> reg_req_out at N+1, core_reg_ack one cycle after return, rd_data=0x12345678.
REQ-032 Read to unclaimed address (return with ack=0) -> core_reg_ack with rd_data=0xdeadbeef.
REQ-033 Write addr 0x40 data 0xA5A5A5A5 -> ring shows rd_wr_L=0, addr 0x40, data 0xA5A5A5A5, src=SRC_ADDR; single core_reg_ack after return.
REQ-034 With TIMEOUT_EN, TIMEOUT=127, ring open -> core_reg_ack exactly 127 WAIT cycles later, rd_data=0xdeadbeef; without macro -> no ack after 1000 cycles.
REQ-035 Second core_reg_req during WAIT, foreign-src return (src=SRC_ADDR+1) -> both ignored; only the one matching return acks.
REQ-036 reset asserted during WAIT, then matching return -> no core_reg_ack; next request completes normally.
